dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width.
REQ-002 SHALL have parameter DM_ADDRESS, default 9: byte-address width, giving 512 bytes (128 words).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..7: wait states inserted per access.
REQ-004 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, DM_ADDRESS: byte address.
REQ-010 SHALL have port req_wdata, input, DATA_W: store data, with the active bytes right-aligned.
REQ-011 SHALL have port req_funct3, input, 3: access size and sign, using RISC-V load/store funct3 encoding.
REQ-012 SHALL have port rsp_valid, output, 1: one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata, output, DATA_W: load result, already extended.
REQ-014 SHALL have port rsp_err, output, 1: access was misaligned or illegal; valid only while rsp_valid is high.
REQ-015 SHALL have port busy, output, 1: a request is in flight.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE, and busy=1 only in WAIT or RESP.
REQ-018 SHALL accept a request on an edge where req_valid && req_ready, latching we, addr, wdata and funct3; req_* is ignored in every other state.
REQ-019 SHALL transition on accept to WAIT with the counter loaded to WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-021 SHALL remain in RESP for exactly one cycle, with rsp_valid=1, then return to IDLE; no new request can be accepted in that cycle.
REQ-022 SHALL give a latency of exactly WAIT_CYCLES+1 cycles from the accept edge to the rsp_valid cycle, with a throughput of one access per WAIT_CYCLES+2 cycles.
REQ-023 SHALL decode loads as: funct3 0 LB (sign-extended byte), 1 LH (sign-extended half), 2 LW, 4 LBU (zero-extended byte), 5 LHU (zero-extended half).
REQ-024 SHALL decode stores as: funct3 0 SB, 1 SH, 2 SW.
REQ-025 SHALL use little-endian byte lanes: the byte at address a lives in word a[DM_ADDRESS-1:2], lane a[1:0].
REQ-026 SHALL write only the addressed lanes on a store; all other bytes are preserved.
REQ-027 SHALL set rsp_err=1 when any of the following holds:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=0;
- load funct3 of 3, 6 or 7;
- store funct3 of 3 to 7.
REQ-028 SHALL, on an erroring access, leave memory unmodified and return rsp_rdata=0.
REQ-029 SHALL commit a store to memory on the edge that enters RESP; before that edge memory is unchanged.
REQ-030 SHALL drive rsp_rdata from the memory contents sampled on the edge entering RESP, and hold it at 0 whenever rsp_valid=0.
REQ-031 SHALL ignore the unused upper req_wdata bits for SB and SH.
REQ-032 SHALL not clear memory contents on reset; contents after power-up are undefined unless preloaded by the bench.

Reset
REQ-033 SHALL, while reset is high, force state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, req_ready=0.
REQ-034 SHALL drive req_ready=1 in the first cycle after reset deasserts.
REQ-035 SHALL, when reset is asserted in WAIT, abort the in-flight store with no memory write and produce no response.
REQ-036 SHALL ignore a request presented in the same cycle as reset.

Verification
REQ-037 SHALL cover: WAIT_CYCLES=2, SW addr 0x010 data 0xDEADBEEF accepted at edge N -> rsp_valid high only in cycle N+3, rsp_err=0; then LW 0x010 -> rsp_rdata=0xDEADBEEF.
REQ-038 SHALL cover: after REQ-037, SB addr 0x011 data 0x123456AB -> LW 0x010 returns 0xDEADABEF; LB 0x011 returns 0xFFFFFFAB; LBU 0x011 returns 0x000000AB; LHU 0x012 returns 0x0000DEAD.
REQ-039 SHALL cover: LH addr 0x013 -> rsp_err=1, rsp_rdata=0; SW addr 0x012 data 0 -> rsp_err=1, and a following LW 0x010 is unchanged.
REQ-040 SHALL cover: req_valid held high continuously -> exactly one accept per 4 cycles (WAIT_CYCLES=2); req_ready=0 throughout WAIT and RESP.
REQ-041 SHALL cover: SW 0x020 data 0x55 with reset asserted one cycle after accept -> no rsp_valid, req_ready=1 in the first cycle after reset deasserts, and a following LW 0x020 returns the prior contents.
REQ-042 SHALL cover: WAIT_CYCLES=0, LW accepted at edge N -> rsp_valid in cycle N+1; next accept at edge N+2.

Source files
------------

// File: rtl/dmem_responder.sv
// Byte-addressable data memory that answers one load/store at a time after a
// fixed number of wait states, with RISC-V sized/signed access decoding.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int LANES   = DATA_W / 8;
    localparam int WORD_AW = DM_ADDRESS - 2;
    localparam int DEPTH   = 1 << WORD_AW;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic                    we_reg;
    logic [DM_ADDRESS-1:0]   addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [2:0]              funct3_reg;
    logic                    err_reg;

    logic                    accept;
    logic                    enter_resp;
    logic                    in_idle;
    logic                    cur_we;
    logic [DM_ADDRESS-1:0]   cur_addr;
    logic [DATA_W-1:0]       cur_wdata;
    logic [2:0]              cur_funct3;
    logic                    cur_err;
    logic [LANES-1:0]        be;
    logic [DATA_W-1:0]       wr_data;
    logic                    mem_we;
    logic [WORD_AW-1:0]      word_idx;
    logic [DATA_W-1:0]       rd_word;
    logic [DATA_W-1:0]       byte_sel;
    logic [DATA_W-1:0]       half_sel;
    logic [DATA_W-1:0]       load_data;

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_next == RESP) && (state_reg != RESP) && !reset;

    // With zero wait states the access completes on the accept edge itself,
    // so the memory port must see the live request instead of the latched one.
    assign in_idle    = (state_reg == IDLE);
    assign cur_we     = in_idle ? req_we     : we_reg;
    assign cur_addr   = in_idle ? req_addr   : addr_reg;
    assign cur_wdata  = in_idle ? req_wdata  : wdata_reg;
    assign cur_funct3 = in_idle ? req_funct3 : funct3_reg;
    assign word_idx   = cur_addr[DM_ADDRESS-1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 3'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (!reset) begin
            case (state_reg)
                IDLE: req_ready = 1'b1;
                WAIT: busy = 1'b1;
                RESP: begin
                    busy      = 1'b1;
                    rsp_valid = 1'b1;
                    rsp_err   = err_reg;
                    if (!we_reg && !err_reg) rsp_rdata = load_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg     <= req_we;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            funct3_reg <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)           err_reg <= 1'b0;
        else if (enter_resp) err_reg <= cur_err;
    end

    // funct3[2] is only legal for the unsigned loads LBU/LHU.
    always_comb begin
        cur_err = 1'b0;
        case (cur_funct3[1:0])
            2'd1:    cur_err = cur_addr[0];
            2'd2:    cur_err = |cur_addr[1:0];
            2'd3:    cur_err = 1'b1;
            default: cur_err = 1'b0;
        endcase
        if (cur_funct3[2] && (cur_we || cur_funct3[1])) cur_err = 1'b1;
    end

    always_comb begin
        be      = '0;
        wr_data = cur_wdata;
        case (cur_funct3[1:0])
            2'd0: begin
                be[cur_addr[1:0]] = 1'b1;
                wr_data           = {LANES{cur_wdata[7:0]}};
            end
            2'd1: begin
                be[{cur_addr[1], 1'b0} +: 2] = 2'b11;
                wr_data                      = {(LANES/2){cur_wdata[15:0]}};
            end
            default: be = '1;
        endcase
    end

    assign mem_we = enter_resp && cur_we && !cur_err;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_lane_reg;

        always_ff @(posedge clk) begin
            if (mem_we && be[gi]) mem[word_idx] <= wr_data[gi*8 +: 8];
            if (enter_resp)       rd_lane_reg   <= mem[word_idx];
        end

        assign rd_word[gi*8 +: 8] = rd_lane_reg;
    end

    assign byte_sel = rd_word >> {addr_reg[1:0], 3'b000};
    assign half_sel = rd_word >> {addr_reg[1], 4'b0000};

    always_comb begin
        load_data = rd_word;
        case (funct3_reg)
            3'd0:    load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel[7:0]};
            3'd1:    load_data = {{(DATA_W-16){half_sel[15]}}, half_sel[15:0]};
            3'd4:    load_data = {{(DATA_W-8){1'b0}}, byte_sel[7:0]};
            3'd5:    load_data = {{(DATA_W-16){1'b0}}, half_sel[15:0]};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, random traffic
// against a byte-array model, and hand sequences for timing and reset corners.
module tb_dmem_responder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [8:0]  z_req_addr;
    logic [31:0] z_req_wdata;
    logic [2:0]  z_req_funct3;
    logic        z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mem_m [512];

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t        vt [20];
    logic [31:0] e_rd, prior;
    logic        e_er;
    logic        r_we;
    logic [8:0]  r_addr;
    logic [31:0] r_wd;
    logic [2:0]  r_f3;
    int          n_acc;

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as plain bytes, access rules applied with arithmetic.
    function automatic void model(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] rd, output logic er);
        int sz;
        bit sgn;
        bit bad;
        longint unsigned v;
        sz = 4; sgn = 0; bad = 0; rd = '0; er = 1'b0;
        if (we) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                default: bad = 1;
            endcase
        end else begin
            case (f3)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 4;
                3'd4: sz = 1;
                3'd5: sz = 2;
                default: bad = 1;
            endcase
        end
        if (!bad && (int'(addr) % sz) != 0) bad = 1;
        if (bad) begin
            er = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < sz; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (longint'(mem_m[int'(addr) + i]) << (8*i));
            if (sgn && v[8*sz-1]) v = v - (64'd1 << (8*sz));
            rd = v[31:0];
        end
    endfunction

    // Issue one request, wait for it to be accepted, then time its response.
    task automatic access(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic er,
                          output int lat);
        int guard;
        int stray;
        rd = '0; er = 1'b0; lat = 0; stray = 0; guard = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 20), 32'd1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = 9'($urandom);
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
                stray++;
        end
        chk("in_flight_flags", 32'(stray), 32'd0);
        if (lat != 0) begin
            @(negedge clk);
            chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
            chk("ready_after_rsp", 32'(req_ready), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input string tag, input logic we, input logic [8:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic er;
        int lat;
        access(we, addr, wd, f3, rd, er, lat);
        $display("txn %s we=%0d f3=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 tag, we, f3, addr, wd, rd, er, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h000; req_wdata = 32'h0; req_funct3 = 3'd2;
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 9'h000; z_req_wdata = 32'h0; z_req_funct3 = 3'd2;

        // Reset: outputs held low, request presented during reset is dropped.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_z_req_ready", 32'(z_req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; z_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_z_ready", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;

        // Give every word a defined value so later loads are predictable.
        for (int w = 0; w < 128; w++) begin
            r_wd = $urandom;
            model(1'b1, 9'(w * 4), r_wd, 3'd2, e_rd, e_er);
            run_txn("preload", 1'b1, 9'(w * 4), r_wd, 3'd2, e_rd, e_er);
        end

        vt[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 9'h010, 32'h00000000, 3'd2, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 9'h011, 32'h123456AB, 3'd0, 32'h00000000, 1'b0};
        vt[3]  = '{1'b0, 9'h010, 32'h00000000, 3'd2, 32'hDEADABEF, 1'b0};
        vt[4]  = '{1'b0, 9'h011, 32'h00000000, 3'd0, 32'hFFFFFFAB, 1'b0};
        vt[5]  = '{1'b0, 9'h011, 32'h00000000, 3'd4, 32'h000000AB, 1'b0};
        vt[6]  = '{1'b0, 9'h012, 32'h00000000, 3'd5, 32'h0000DEAD, 1'b0};
        vt[7]  = '{1'b0, 9'h012, 32'h00000000, 3'd1, 32'hFFFFDEAD, 1'b0};
        vt[8]  = '{1'b0, 9'h013, 32'h00000000, 3'd1, 32'h00000000, 1'b1};
        vt[9]  = '{1'b1, 9'h012, 32'h00000000, 3'd2, 32'h00000000, 1'b1};
        vt[10] = '{1'b0, 9'h010, 32'h00000000, 3'd2, 32'hDEADABEF, 1'b0};
        vt[11] = '{1'b1, 9'h014, 32'h11223344, 3'd2, 32'h00000000, 1'b0};
        vt[12] = '{1'b1, 9'h016, 32'hABCD9876, 3'd1, 32'h00000000, 1'b0};
        vt[13] = '{1'b0, 9'h014, 32'h00000000, 3'd2, 32'h98763344, 1'b0};
        vt[14] = '{1'b0, 9'h014, 32'h00000000, 3'd3, 32'h00000000, 1'b1};
        vt[15] = '{1'b1, 9'h014, 32'hFFFFFFFF, 3'd4, 32'h00000000, 1'b1};
        vt[16] = '{1'b0, 9'h014, 32'h00000000, 3'd2, 32'h98763344, 1'b0};
        vt[17] = '{1'b0, 9'h017, 32'h00000000, 3'd0, 32'hFFFFFF98, 1'b0};
        vt[18] = '{1'b0, 9'h016, 32'h00000000, 3'd1, 32'hFFFF9876, 1'b0};
        vt[19] = '{1'b0, 9'h013, 32'h00000000, 3'd2, 32'h00000000, 1'b1};

        for (int i = 0; i < 20; i++) begin
            model(vt[i].we, vt[i].addr, vt[i].wd, vt[i].f3, e_rd, e_er);
            run_txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wd, vt[i].f3,
                    vt[i].rd, vt[i].er);
        end

        // Random mixed traffic against the byte model.
        for (int i = 0; i < 250; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = 9'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & 9'h1FC;
            r_wd   = $urandom;
            model(r_we, r_addr, r_wd, r_f3, e_rd, e_er);
            run_txn("rand", r_we, r_addr, r_wd, r_f3, e_rd, e_er);
        end

        // Back-to-back requests: one accept every 4 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'd2;
        n_acc = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready === 1'b1) n_acc++;
            chk($sformatf("stream_ready_c%0d", c), 32'(req_ready), 32'((c % 4) == 0));
            chk($sformatf("stream_busy_c%0d", c), 32'(busy), 32'((c % 4) != 0));
            chk($sformatf("stream_rsp_c%0d", c), 32'(rsp_valid), 32'((c % 4) == 3));
        end
        $display("txn stream accepts=%0d in 16 cycles", n_acc);
        chk("stream_accepts", 32'(n_acc), 32'd4);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset one cycle after accepting a store aborts it.
        model(1'b1, 9'h020, 32'hA5A5A5A5, 3'd2, e_rd, e_er);
        run_txn("abort_setup", 1'b1, 9'h020, 32'hA5A5A5A5, 3'd2, e_rd, e_er);
        model(1'b0, 9'h020, 32'h0, 3'd2, prior, e_er);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h55; req_funct3 = 3'd2;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_rst_rsp2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_post_ready", 32'(req_ready), 32'd1);
        chk("abort_post_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_post_busy", 32'(busy), 32'd0);
        $display("txn abort SW 0x020 data 0x00000055 reset after accept");
        @(posedge clk); #1;
        run_txn("abort_check", 1'b0, 9'h020, 32'h0, 3'd2, prior, 1'b0);

        // Zero wait states: response the cycle after accept, next accept one cycle later.
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 9'h004;
        z_req_wdata = 32'hCAFE0123; z_req_funct3 = 3'd2;
        @(negedge clk);
        chk("w0_ready0", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_we = 1'b0;
        @(negedge clk);
        chk("w0_rsp_store", 32'(z_rsp_valid), 32'd1);
        chk("w0_err_store", 32'(z_rsp_err), 32'd0);
        chk("w0_ready_in_resp", 32'(z_req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w0_rsp_gap", 32'(z_rsp_valid), 32'd0);
        chk("w0_ready_again", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        @(negedge clk);
        chk("w0_rsp_load", 32'(z_rsp_valid), 32'd1);
        chk("w0_rdata_load", z_rsp_rdata, 32'hCAFE0123);
        $display("txn w0 LW 0x004 -> rdata=0x%08h", z_rsp_rdata);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w0_idle_rsp", 32'(z_rsp_valid), 32'd0);
        chk("w0_idle_rdata", z_rsp_rdata, 32'd0);
        chk("w0_idle_busy", 32'(z_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
